// File: rtl/crc_engine_par_if.sv
// Beat stream into the parallel CRC engine and the frame result coming back.
// The upstream framer uses master, the engine uses slave.
interface crc_engine_par_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              crc_valid;
  logic [CRC_W-1:0]  crc_out;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, crc_valid, crc_out
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, crc_valid, crc_out
  );
endinterface

// File: rtl/crc_engine_par.sv
// Streaming CRC engine: DATA_W serial LFSR steps per accepted beat, MSB first.
// Define CRC_CHECK_EN to add receive-side residue checking (check_mode, crc_ok, err_cnt).
module crc_engine_par #(
  parameter int unsigned        CRC_W   = 8,
  parameter logic [CRC_W-1:0]   POLY    = 8'h2F,
  parameter logic [CRC_W-1:0]   INIT    = 8'hFF,
  parameter logic [CRC_W-1:0]   XOR_OUT = 8'h00,
  parameter int unsigned        DATA_W  = 8,
  parameter int unsigned        CNT_W   = 16
`ifdef CRC_CHECK_EN
  ,
  parameter logic [CRC_W-1:0]   RESIDUE = '0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  crc_engine_par_if.slave  s,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
`ifdef CRC_CHECK_EN
  ,
  input  logic             check_mode,
  output logic             crc_ok,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_next;
  logic             accept;
`ifdef CRC_CHECK_EN
  logic             mode_q, mode_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] err_q, err_d;
`endif

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = r_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  assign s.s_ready   = (state_q != StDone);
  assign s.crc_valid = (state_q == StDone);
  assign s.crc_out   = out_q;
  assign busy        = (state_q == StActive) || (state_q == StDone);
  assign frame_cnt   = cnt_q;
  assign accept      = s.s_valid & s.s_ready;
  assign crc_next    = crc_step(crc_q, s.s_data);
`ifdef CRC_CHECK_EN
  assign crc_ok      = ok_q;
  assign err_cnt     = err_q;
`endif

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
`ifdef CRC_CHECK_EN
    mode_d  = mode_q;
    ok_d    = ok_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle, StActive: begin
        if (accept) begin
          crc_d = crc_next;
`ifdef CRC_CHECK_EN
          if (state_q == StIdle) mode_d = check_mode;
`endif
          if (s.s_last) begin
            out_d   = crc_next ^ XOR_OUT;
            state_d = StDone;
          end else begin
            state_d = StActive;
          end
        end
      end
      StDone: begin
        crc_d   = INIT;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StIdle;
`ifdef CRC_CHECK_EN
        // crc_q still holds the whole frame including the received CRC here
        ok_d = mode_q && (crc_q == RESIDUE);
        if (mode_q && (crc_q != RESIDUE) && (err_q != '1)) err_d = err_q + CNT_W'(1);
`endif
      end
      default: state_d = StIdle;
    endcase
    if (init) begin
      state_d = StIdle;
      crc_d   = INIT;
      out_d   = '0;
      cnt_d   = '0;
`ifdef CRC_CHECK_EN
      mode_d  = 1'b0;
      ok_d    = 1'b0;
      err_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      out_q   <= '0;
      cnt_q   <= '0;
`ifdef CRC_CHECK_EN
      mode_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
`ifdef CRC_CHECK_EN
      mode_q  <= mode_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_crc_engine_par.sv
// Self-checking bench for crc_engine_par: three configurations, table vectors,
// randomized frames against a bit-serial reference model, and corner-case sequences.
module tb_crc_engine_par;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init = 1'b0;
  logic cm = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // 0: CRC-8 0x2F, 8-bit beats; 1: same CRC, 1-bit beats, XOR_OUT 0xFF; 2: CRC-4 0x3, CNT_W 2
  crc_engine_par_if #(.DATA_W(8), .CRC_W(8)) if8 ();
  crc_engine_par_if #(.DATA_W(1), .CRC_W(8)) if1 ();
  crc_engine_par_if #(.DATA_W(8), .CRC_W(4)) if4 ();

  logic        busy8, busy1, busy4;
  logic [15:0] cnt8, cnt1;
  logic [1:0]  cnt4;
`ifdef CRC_CHECK_EN
  logic        ok8, ok1, ok4;
  logic [15:0] err8, err1;
  logic [1:0]  err4;
`endif

  crc_engine_par #(.CRC_W(8), .POLY(8'h2F), .INIT(8'hFF), .XOR_OUT(8'h00), .DATA_W(8),
                   .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .init(init), .s(if8), .busy(busy8), .frame_cnt(cnt8)
`ifdef CRC_CHECK_EN
    , .check_mode(cm), .crc_ok(ok8), .err_cnt(err8)
`endif
  );

  crc_engine_par #(.CRC_W(8), .POLY(8'h2F), .INIT(8'hFF), .XOR_OUT(8'hFF), .DATA_W(1),
                   .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .init(init), .s(if1), .busy(busy1), .frame_cnt(cnt1)
`ifdef CRC_CHECK_EN
    , .check_mode(cm), .crc_ok(ok1), .err_cnt(err1)
`endif
  );

  crc_engine_par #(.CRC_W(4), .POLY(4'h3), .INIT(4'hF), .XOR_OUT(4'h0), .DATA_W(8),
                   .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .init(init), .s(if4), .busy(busy4), .frame_cnt(cnt4)
`ifdef CRC_CHECK_EN
    , .check_mode(cm), .crc_ok(ok4), .err_cnt(err4)
`endif
  );

  // Every crc_valid pulse seen on a falling edge is logged, so extra or missing pulses show up.
  logic [7:0] mon8[$];
  logic [7:0] mon1[$];
  logic [3:0] mon4[$];
  always @(negedge clk) begin
    if (if8.crc_valid) mon8.push_back(if8.crc_out);
    if (if1.crc_valid) mon1.push_back(if1.crc_out);
    if (if4.crc_valid) mon4.push_back(if4.crc_out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: the serial LFSR rule applied to the frame flattened into a bit list.
  function automatic logic [7:0] ref_crc(input int w, input logic [7:0] fr[$]);
    int         cw;
    logic [7:0] poly, r, xo, mask;
    logic       fb;
    bit         bits[$];
    if (w == 2) begin
      cw = 4; poly = 8'h03; r = 8'h0F; xo = 8'h00; mask = 8'h0F;
    end else begin
      cw = 8; poly = 8'h2F; r = 8'hFF; xo = (w == 1) ? 8'hFF : 8'h00; mask = 8'hFF;
    end
    foreach (fr[i]) for (int b = 7; b >= 0; b--) bits.push_back(fr[i][b]);
    foreach (bits[k]) begin
      fb = r[cw-1] ^ bits[k];
      r  = (r << 1) & mask;
      if (fb) r = r ^ poly;
    end
    return r ^ xo;
  endfunction

  function automatic logic rdy(input int w);
    if (w == 0) return if8.s_ready;
    if (w == 1) return if1.s_ready;
    return if4.s_ready;
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] d, input logic l);
    if (w == 0) begin if8.s_valid = v; if8.s_data = d; if8.s_last = l; end
    else if (w == 1) begin if1.s_valid = v; if1.s_data = d[0]; if1.s_last = l; end
    else begin if4.s_valid = v; if4.s_data = d; if4.s_last = l; end
  endtask

  // Offer a beat on the falling edge, hold it until ready, return just after acceptance.
  task automatic beat(input int w, input logic [7:0] d, input logic l, output int waited);
    @(negedge clk);
    drive(w, 1'b1, d, l);
    waited = 0;
    while (!rdy(w) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'(rdy(w)), 1);
    @(posedge clk);
  endtask

  task automatic idle(input int w);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom), 1'b0);
  endtask

  function automatic int mon_size(input int w);
    if (w == 0) return mon8.size();
    if (w == 1) return mon1.size();
    return mon4.size();
  endfunction

  task automatic mon_pop(input int w, output logic [7:0] v);
    if (w == 0) v = mon8.pop_front();
    else if (w == 1) v = mon1.pop_front();
    else v = {4'h0, mon4.pop_front()};
  endtask

  task automatic mon_clear();
    mon8.delete(); mon1.delete(); mon4.delete();
  endtask

  task automatic send_frame(input int w, input logic [7:0] fr[$], input bit gaps);
    int  wt;
    int  n;
    bit  l;
    n = fr.size();
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (w != 1 && b != 7) break;
        l = (i == n - 1) && (w != 1 || b == 0);
        beat(w, (w == 1) ? {7'h0, fr[i][b]} : fr[i], l, wt);
        if (gaps && !l && ($urandom_range(0, 2) == 0)) idle(w);
      end
    end
    idle(w);
    @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int w, input logic [7:0] fr[$],
                             input bit gaps, input logic [7:0] exp);
    logic [7:0] v;
    send_frame(w, fr, gaps);
    check({nm, "_pulses"}, 32'(mon_size(w)), 1);
    if (mon_size(w) >= 1) begin
      mon_pop(w, v);
      check(nm, {24'h0, v}, {24'h0, exp});
    end
    mon_clear();
  endtask

  typedef struct {
    int         n;
    logic [7:0] d[9];
    logic [7:0] exp;
  } vec_t;

  vec_t       tab[3];
  logic [7:0] fr[$];
  logic [7:0] v;
  logic [7:0] d4[5];
  int         wt;
  int         e8;

  initial begin
    tab[0].n = 1; tab[0].d[0] = 8'h00; tab[0].exp = 8'h42;
    tab[1].n = 1; tab[1].d[0] = 8'hFF; tab[1].exp = 8'h00;
    tab[2].n = 9; tab[2].exp = 8'h20;
    for (int i = 0; i < 9; i++) tab[2].d[i] = 8'h31 + 8'(i);
    drive(0, 0, 0, 0); drive(1, 0, 0, 0); drive(2, 0, 0, 0);

    #2;
    check("rst_ready", 32'(if8.s_ready), 1);
    check("rst_valid", 32'(if8.crc_valid), 0);
    check("rst_crc", 32'(if8.crc_out), 0);
    check("rst_busy", 32'(busy8), 0);
    check("rst_cnt", 32'(cnt8), 0);
    check("rst_cnt4", 32'(cnt4), 0);
    @(negedge clk);
    rst = 1'b1;

    // single zero beat: one-cycle DONE with s_ready low, then back to idle
    beat(0, 8'h00, 1'b1, wt);
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("done_valid", 32'(if8.crc_valid), 1);
    check("done_crc", 32'(if8.crc_out), 32'h42);
    check("done_ready", 32'(if8.s_ready), 0);
    check("done_busy", 32'(busy8), 1);
    check("done_cnt", 32'(cnt8), 0);
    @(negedge clk);
    check("after_valid", 32'(if8.crc_valid), 0);
    check("after_ready", 32'(if8.s_ready), 1);
    check("after_busy", 32'(busy8), 0);
    check("after_cnt", 32'(cnt8), 1);
    check("after_crc_hold", 32'(if8.crc_out), 32'h42);
    check("after_pulses", 32'(mon8.size()), 1);
    mon_clear();
    e8 = 1;

    for (int g = 0; g < 2; g++) begin
      for (int t = 0; t < 3; t++) begin
        fr = {};
        for (int i = 0; i < tab[t].n; i++) fr.push_back(tab[t].d[i]);
        check_frame($sformatf("tab%0d_gap%0d", t, g), 0, fr, g[0], tab[t].exp);
        e8++;
      end
    end
    check("tab_cnt", 32'(cnt8), 32'(e8));

    for (int k = 0; k < 16; k++) begin
      fr = {};
      for (int i = 0; i < $urandom_range(1, 5); i++) fr.push_back(8'($urandom));
      check_frame($sformatf("rand8_%0d", k), 0, fr, 1'b1, ref_crc(0, fr));
      e8++;
    end
    check("rand_cnt", 32'(cnt8), 32'(e8));

    // init while idle clears the count; a mid-frame init then discards the frame
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    check("init_idle_cnt", 32'(cnt8), 0);
    for (int i = 0; i < 4; i++) beat(0, 8'($urandom), 1'b0, wt);
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("mid_busy", 32'(busy8), 1);
    init = 1'b1;
    @(negedge clk); init = 1'b0;
    check("init_busy", 32'(busy8), 0);
    check("init_ready", 32'(if8.s_ready), 1);
    // a last beat offered together with init is dropped
    drive(0, 1, 8'h00, 1);
    init = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0);
    init = 1'b0;
    repeat (3) @(negedge clk);
    check("init_no_pulse", 32'(mon8.size()), 0);
    check("init_cnt", 32'(cnt8), 0);
    check("init_busy2", 32'(busy8), 0);
    fr = '{8'h00};
    check_frame("post_init", 0, fr, 1'b0, 8'h42);
    check("post_init_cnt", 32'(cnt8), 1);

`ifdef CRC_CHECK_EN
    cm = 1'b1;
    fr = '{8'h00, 8'h42};
    check_frame("chk_good", 0, fr, 1'b0, ref_crc(0, fr));
    check("chk_good_ok", 32'(ok8), 1);
    check("chk_good_err", 32'(err8), 0);
    fr = '{8'h00, 8'h43};
    check_frame("chk_bad", 0, fr, 1'b1, ref_crc(0, fr));
    check("chk_bad_ok", 32'(ok8), 0);
    check("chk_bad_err", 32'(err8), 1);
    cm = 1'b0;
    check_frame("gen_mode", 0, fr, 1'b0, ref_crc(0, fr));
    check("gen_ok", 32'(ok8), 0);
    check("gen_err", 32'(err8), 1);
`endif

    // 1-bit beats: the same CRC as byte beats, here with XOR_OUT 0xFF
    fr = '{8'h00};
    check_frame("bit_zero", 1, fr, 1'b1, 8'hBD);
    fr = {};
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    check_frame("bit_check", 1, fr, 1'b1, 8'hDF);
    for (int k = 0; k < 3; k++) begin
      fr = {};
      for (int i = 0; i < $urandom_range(1, 3); i++) fr.push_back(8'($urandom));
      check_frame($sformatf("rand1_%0d", k), 1, fr, 1'b1, ref_crc(1, fr));
    end

    // CRC-4: back-to-back single-beat frames, each held off one cycle by DONE; count wraps
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    for (int f = 0; f < 5; f++) begin
      d4[f] = 8'($urandom);
      beat(2, d4[f], 1'b1, wt);
      if (f > 0) check($sformatf("holdoff_%0d", f), 32'(wt), 1);
    end
    idle(2);
    @(negedge clk);
    check("wrap_pulses", 32'(mon4.size()), 5);
    for (int f = 0; f < 5; f++) begin
      if (mon4.size() > 0) begin
        mon_pop(2, v);
        fr = '{d4[f]};
        check($sformatf("wrap_crc_%0d", f), 32'(v), 32'(ref_crc(2, fr)));
      end
    end
    check("wrap_cnt", 32'(cnt4), 1);
    mon_clear();
    for (int k = 0; k < 4; k++) begin
      fr = {};
      for (int i = 0; i < $urandom_range(1, 4); i++) fr.push_back(8'($urandom));
      check_frame($sformatf("rand4_%0d", k), 2, fr, 1'b1, ref_crc(2, fr));
    end

    // asynchronous reset mid-frame takes effect without a clock edge
    for (int i = 0; i < 3; i++) beat(0, 8'($urandom), 1'b0, wt);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy8), 0);
    check("arst_ready", 32'(if8.s_ready), 1);
    check("arst_valid", 32'(if8.crc_valid), 0);
    check("arst_crc", 32'(if8.crc_out), 0);
    check("arst_cnt", 32'(cnt8), 0);
`ifdef CRC_CHECK_EN
    check("arst_ok", 32'(ok8), 0);
    check("arst_err", 32'(err8), 0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_pulse", 32'(mon8.size()), 0);
    fr = '{8'h00};
    check_frame("post_arst", 0, fr, 1'b0, 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
